pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Parametrised pipeline control unit for the N-stage RV32 core: stall/flush generation, load-use interlock,
//  per-stage occupancy tracking, and a debug halt/step/resume FSM with a drain watchdog.
//  Sits beside the stage modules; it drives every stage's stall/flush and the IF fetch enable.
// PARAMETERS
//  NSTAGES    5  pipeline depth; index 0 = IF (youngest) ... NSTAGES-1 = WB (oldest)
//  LU_STAGE   1  stage held by load-use interlock (ID); stage LU_STAGE+1 receives the bubble
//  DRAIN_MAX 16  max DRAIN cycles before forced flush-to-halt
// PORTS
//  iClk           in  1        clock
//  nRst           in  1        async active-low reset
//  iStallReq      in  NSTAGES  stage i cannot advance (cache miss, memory wait)
//  iFlushReq      in  NSTAGES  stage i redirects; kill all younger stages (index < i)
//  iLoadUse       in  1        load-use hazard detected at LU_STAGE
//  iDbgHaltReq    in  1        debugger halt request (level)
//  iDbgResumeReq  in  1        debugger resume (level, sampled in HALTED)
//  iDbgStepReq    in  1        debugger single-step (level, sampled in HALTED)
//  oStall         out NSTAGES  hold stage i register
//  oFlush         out NSTAGES  clear stage i register to bubble
//  oOccupied      out NSTAGES  stage i holds a valid instruction
//  oFetchEn       out 1        IF may inject a new instruction this cycle
//  oDbgHalted     out 1        core halted, pipeline empty
//  oDrainTimeout  out 1        sticky: last halt forced by watchdog; cleared on leaving HALTED
//  oPerfStall     out 32       stall-cycle counter (PIPE_PERF_EN)
//  oPerfFlush     out 32       flush-event counter (PIPE_PERF_EN)
// BEHAVIOUR
//  Reset (async, nRst=0): state=RUN, oOccupied=0, watchdog=0, oDbgHalted=0, oDrainTimeout=0, perf=0;
//   oFlush forced all-ones while nRst=0; oStall=0.
//  Stall: stall[i] = |iStallReq[NSTAGES-1:i] | (iLoadUse & i<=LU_STAGE) | (state==HALTED).
//  Flush: iFlushReq[i] ignored when stall[i]=1 (requester holds it). Accepted flush from i sets oFlush[j] for j<i.
//   Load-use sets oFlush[LU_STAGE+1] unless stall[LU_STAGE+1]. DRAIN timeout sets oFlush all-ones for 1 cycle.
//   Flush beats stall on the same stage: oStall[j]=stall[j]&~oFlush[j].
//  Occupancy (registered): occ[i]' = oFlush[i] ? 0 : oStall[i] ? occ[i] : (i==0 ? oFetchEn : ~oStall[i-1] & occ[i-1]).
//  Multiple flush requests in one cycle: union applies (oldest requester effectively wins).
//  oFetchEn = ~stall[0] & (state==RUN | (state==STEP & ~stepDone)).
//  FSM (registered):
//   RUN    : iDbgHaltReq -> DRAIN (fetch stops same cycle as transition).
//   DRAIN  : occ==0 -> HALTED. Watchdog counts DRAIN cycles; reaching DRAIN_MAX -> flush all,
//            set oDrainTimeout, -> HALTED. Halt/step/resume ignored in DRAIN.
//   HALTED : oDbgHalted=1, all stages stalled. iDbgResumeReq -> RUN; else iDbgStepReq -> STEP.
//            Resume+step same cycle: resume wins. Leaving HALTED clears oDrainTimeout and watchdog.
//   STEP   : exactly one instruction injected (first cycle with ~stall[0]), then -> DRAIN -> HALTED.
//  Latency: halt request to oDbgHalted = cycles to drain occupied stages + 1 (FSM register).
//  Reset mid-DRAIN/STEP: immediate return to RUN, pipeline flushed, no partial step retained.
// CONFIGURATION
//  PIPE_PERF_EN defined: oPerfStall increments each RUN cycle with oStall[0]=1; oPerfFlush increments
//   each cycle with any accepted iFlushReq; both wrap at 2^32.
//  Not defined: counters not built; oPerfStall/oPerfFlush tied to 0.
// STRUCTURE
//  pipeline_types package: dbg_state_e {RUN,DRAIN,HALTED,STEP}; stage index constants STG_IF..STG_WB.
//  Sub-module pipe_occupancy: occupancy shift register (inputs stall, flush, fetchEn; output occ).
// TESTING
//  1 iStallReq[3]=1 for 3 cycles, NSTAGES=5 -> oStall=5'b01111 those cycles, oFlush=0, occ[4] drains to 0.
//  2 iFlushReq[2]=1, stage 2 unstalled -> oFlush=5'b00011 one cycle, occ[1:0]=0 next cycle.
//  3 iLoadUse=1 one cycle -> oStall=5'b00011, oFlush[2]=1; occ[2]=0 next cycle.
//  4 full pipe, iDbgHaltReq -> oFetchEn=0, oDbgHalted=1 after 6 cycles; iDbgStepReq -> one occ bit walks 0..4, halted again.
//  5 HALTED with resume+step same cycle -> RUN, oFetchEn=1 next cycle, no STEP.
//  6 DRAIN with iStallReq[3] held -> at DRAIN_MAX=16: oFlush=5'b11111, oDrainTimeout=1, oDbgHalted=1.

Source files
------------

// File: rtl/pipeline_types.sv
// rtl/pipeline_types.sv - shared types and stage indices for the pipeline control unit
package pipeline_types;

  // Debug run-control states
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } dbg_state_e;

  // Stage indices, youngest (IF) to oldest (WB)
  localparam int STG_WB  = 4;
  localparam int STG_MEM = STG_WB - 1;
  localparam int STG_EX  = STG_MEM - 1;
  localparam int STG_ID  = STG_EX - 1;
  localparam int STG_IF  = STG_ID - 1;

endpackage

// File: rtl/pipe_occupancy.sv
// rtl/pipe_occupancy.sv - per-stage valid-instruction tracking shift register
module pipe_occupancy #(
  parameter int NSTAGES = 5
) (
  input  logic               iClk,
  input  logic               nRst,
  input  logic [NSTAGES-1:0] iStall,
  input  logic [NSTAGES-1:0] iFlush,
  input  logic               iFetchEn,
  output logic [NSTAGES-1:0] oOcc
);

  logic [NSTAGES-1:0] occ_q;
  logic [NSTAGES-1:0] occ_d;
  logic [NSTAGES-1:0] upstream;

  // Next occupancy: flush clears, stall holds, otherwise take what the younger stage hands over
  always_comb begin
    upstream = {occ_q[NSTAGES-2:0] & ~iStall[NSTAGES-2:0], iFetchEn};
    occ_d    = ~iFlush & ((iStall & occ_q) | (~iStall & upstream));
  end

  // Occupancy register, empty after reset
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign oOcc = occ_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush/occupancy control with debug halt FSM; PIPE_PERF_EN adds perf counters
module pipeline_ctrl
  import pipeline_types::*;
#(
  parameter int NSTAGES   = STG_WB + 1,
  parameter int LU_STAGE  = STG_ID,
  parameter int DRAIN_MAX = 16
) (
  input  logic               iClk,
  input  logic               nRst,
  input  logic [NSTAGES-1:0] iStallReq,
  input  logic [NSTAGES-1:0] iFlushReq,
  input  logic               iLoadUse,
  input  logic               iDbgHaltReq,
  input  logic               iDbgResumeReq,
  input  logic               iDbgStepReq,
  output logic [NSTAGES-1:0] oStall,
  output logic [NSTAGES-1:0] oFlush,
  output logic [NSTAGES-1:0] oOccupied,
  output logic               oFetchEn,
  output logic               oDbgHalted,
  output logic               oDrainTimeout,
  output logic [31:0]        oPerfStall,
  output logic [31:0]        oPerfFlush
);

  localparam int WDW = $clog2(DRAIN_MAX + 1);

  dbg_state_e         state_q;
  logic [WDW-1:0]     wdog_q;
  logic               halted_q;
  logic               timeout_q;
  logic               step_done_q;

  logic [NSTAGES-1:0] stall;
  logic [NSTAGES-1:0] flush;
  logic [NSTAGES-1:0] flush_acc;
  logic [NSTAGES-1:0] occ;
  logic               drain_expire;

  // Watchdog fires on the last permitted DRAIN cycle if the pipe still holds work
  assign drain_expire = (state_q == DRAIN) && (occ != '0) &&
                        (wdog_q == WDW'(DRAIN_MAX - 1));

  // Raw stall: any older stage stuck, load-use hold of ID and younger, or halted
  always_comb begin
    stall = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      stall[i] = (|(iStallReq >> i)) | (iLoadUse && (i <= LU_STAGE)) |
                 (state_q == HALTED);
    end
  end

  // Flush: accepted requests kill all younger stages; load-use bubble; watchdog kills all
  always_comb begin
    flush_acc = iFlushReq & ~stall;
    flush     = '0;
    for (int j = 0; j < NSTAGES; j++) begin
      flush[j] = |(flush_acc >> (j + 1));
    end
    if (iLoadUse && !stall[LU_STAGE+1]) begin
      flush[LU_STAGE+1] = 1'b1;
    end
    if (drain_expire) begin
      flush = '1;
    end
  end

  assign oFlush   = nRst ? flush : '1;
  assign oStall   = stall & ~oFlush;
  assign oFetchEn = ~stall[STG_IF] &
                    (((state_q == RUN) & ~iDbgHaltReq) |
                     ((state_q == STEP) & ~step_done_q));

  pipe_occupancy #(
    .NSTAGES (NSTAGES)
  ) u_occ (
    .iClk     (iClk),
    .nRst     (nRst),
    .iStall   (oStall),
    .iFlush   (oFlush),
    .iFetchEn (oFetchEn),
    .oOcc     (occ)
  );

  assign oOccupied = occ;

  // Debug run-control FSM with drain watchdog and registered status outputs
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= RUN;
      wdog_q      <= '0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (iDbgHaltReq) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (occ == '0) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else if (drain_expire) begin
            state_q   <= HALTED;
            halted_q  <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        HALTED: begin
          if (iDbgResumeReq) begin
            state_q   <= RUN;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            wdog_q    <= '0;
          end else if (iDbgStepReq) begin
            state_q     <= STEP;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            wdog_q      <= '0;
            step_done_q <= 1'b0;
          end
        end
        STEP: begin
          if (oFetchEn) begin
            step_done_q <= 1'b1;
            state_q     <= DRAIN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign oDbgHalted    = halted_q;
  assign oDrainTimeout = timeout_q;

`ifdef PIPE_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  // Free-running wrap-around counters of RUN-state IF stalls and accepted flush requests
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if ((state_q == RUN) && oStall[STG_IF]) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (|flush_acc) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign oPerfStall = perf_stall_q;
  assign oPerfFlush = perf_flush_q;
`else
  assign oPerfStall = '0;
  assign oPerfFlush = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int N = 5;

  logic          iClk = 1'b0;
  logic          nRst = 1'b0;
  logic [N-1:0]  iStallReq = '0;
  logic [N-1:0]  iFlushReq = '0;
  logic          iLoadUse = 1'b0;
  logic          iDbgHaltReq = 1'b0;
  logic          iDbgResumeReq = 1'b0;
  logic          iDbgStepReq = 1'b0;
  logic [N-1:0]  oStall;
  logic [N-1:0]  oFlush;
  logic [N-1:0]  oOccupied;
  logic          oFetchEn;
  logic          oDbgHalted;
  logic          oDrainTimeout;
  logic [31:0]   oPerfStall;
  logic [31:0]   oPerfFlush;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [N-1:0] sreq;
    logic [N-1:0] freq;
    logic         lu;
    logic [N-1:0] stall;
    logic [N-1:0] flush;
    logic [N-1:0] occ;
  } row_t;

  exp_t sb[$];
  exp_t e;

  always #5 iClk = ~iClk;

  pipeline_ctrl #(
    .NSTAGES   (N),
    .LU_STAGE  (1),
    .DRAIN_MAX (16)
  ) dut (
    .iClk          (iClk),
    .nRst          (nRst),
    .iStallReq     (iStallReq),
    .iFlushReq     (iFlushReq),
    .iLoadUse      (iLoadUse),
    .iDbgHaltReq   (iDbgHaltReq),
    .iDbgResumeReq (iDbgResumeReq),
    .iDbgStepReq   (iDbgStepReq),
    .oStall        (oStall),
    .oFlush        (oFlush),
    .oOccupied     (oOccupied),
    .oFetchEn      (oFetchEn),
    .oDbgHalted    (oDbgHalted),
    .oDrainTimeout (oDrainTimeout),
    .oPerfStall    (oPerfStall),
    .oPerfFlush    (oPerfFlush)
  );

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic idle_inputs();
    iStallReq = '0; iFlushReq = '0; iLoadUse = 1'b0;
    iDbgHaltReq = 1'b0; iDbgResumeReq = 1'b0; iDbgStepReq = 1'b0;
  endtask

  task automatic refill();
    idle_inputs();
    repeat (5) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    nRst = 1'b0;
    #3;
    sb.push_back(exp_t'{"rst_flush", 32'h1F});
    sb.push_back(exp_t'{"rst_stall_occ_halt_to", 32'h0});
    e = sb.pop_front(); tests_run++;
    if ({27'b0, oFlush} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, oFlush, e.val); end
    e = sb.pop_front(); tests_run++;
    if ({20'b0, oStall, oOccupied, oDbgHalted, oDrainTimeout} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, {oStall, oOccupied, oDbgHalted, oDrainTimeout}, e.val); end
    @(posedge iClk); #1;
    nRst = 1'b1;
  endtask

  task automatic test_fill();
    logic [N-1:0] occ_exp [5];
    occ_exp = '{5'h01, 5'h03, 5'h07, 5'h0F, 5'h1F};
    for (int k = 0; k < 5; k++) begin
      sb.push_back(exp_t'{"fill_occ", {27'b0, occ_exp[k]}});
      tick();
      e = sb.pop_front(); tests_run++;
      if ({27'b0, oOccupied} !== e.val) begin tests_failed++; $display("FAIL %s[%0d] got %0h want %0h", e.name, k, oOccupied, e.val); end
    end
  endtask

  task automatic test_stall();
    row_t rows [4];
    rows = '{
      '{5'b01000, 5'b00000, 1'b0, 5'b01111, 5'b00000, 5'b01111},
      '{5'b01000, 5'b00000, 1'b0, 5'b01111, 5'b00000, 5'b01111},
      '{5'b01000, 5'b00000, 1'b0, 5'b01111, 5'b00000, 5'b01111},
      '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b11111}
    };
    refill();
    foreach (rows[r]) begin
      iStallReq = rows[r].sreq; iFlushReq = rows[r].freq; iLoadUse = rows[r].lu;
      sb.push_back(exp_t'{"stall_sf", {22'b0, rows[r].stall, rows[r].flush}});
      sb.push_back(exp_t'{"stall_occ", {27'b0, rows[r].occ}});
      #3;
      e = sb.pop_front(); tests_run++;
      if ({22'b0, oStall, oFlush} !== e.val) begin tests_failed++; $display("FAIL %s[%0d] got %0h want %0h", e.name, r, {oStall, oFlush}, e.val); end
      tick();
      e = sb.pop_front(); tests_run++;
      if ({27'b0, oOccupied} !== e.val) begin tests_failed++; $display("FAIL %s[%0d] got %0h want %0h", e.name, r, oOccupied, e.val); end
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    row_t rows [9];
    rows = '{
      '{5'b00000, 5'b00100, 1'b0, 5'b00000, 5'b00011, 5'b11100},
      '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b11001},
      '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b10011},
      '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00111},
      '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b01111},
      '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b11111},
      '{5'b01000, 5'b00100, 1'b0, 5'b01111, 5'b00000, 5'b01111},
      '{5'b00000, 5'b00110, 1'b0, 5'b00000, 5'b00011, 5'b11100},
      '{5'b00100, 5'b10000, 1'b0, 5'b00000, 5'b01111, 5'b10000}
    };
    refill();
    foreach (rows[r]) begin
      iStallReq = rows[r].sreq; iFlushReq = rows[r].freq; iLoadUse = rows[r].lu;
      sb.push_back(exp_t'{"flush_sf", {22'b0, rows[r].stall, rows[r].flush}});
      sb.push_back(exp_t'{"flush_occ", {27'b0, rows[r].occ}});
      #3;
      e = sb.pop_front(); tests_run++;
      if ({22'b0, oStall, oFlush} !== e.val) begin tests_failed++; $display("FAIL %s[%0d] got %0h want %0h", e.name, r, {oStall, oFlush}, e.val); end
      tick();
      e = sb.pop_front(); tests_run++;
      if ({27'b0, oOccupied} !== e.val) begin tests_failed++; $display("FAIL %s[%0d] got %0h want %0h", e.name, r, oOccupied, e.val); end
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    row_t rows [3];
    rows = '{
      '{5'b00000, 5'b00000, 1'b1, 5'b00011, 5'b00100, 5'b11011},
      '{5'b00000, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b10111},
      '{5'b00100, 5'b00000, 1'b1, 5'b00111, 5'b00000, 5'b00111}
    };
    refill();
    foreach (rows[r]) begin
      iStallReq = rows[r].sreq; iFlushReq = rows[r].freq; iLoadUse = rows[r].lu;
      sb.push_back(exp_t'{"lu_sf", {22'b0, rows[r].stall, rows[r].flush}});
      sb.push_back(exp_t'{"lu_occ", {27'b0, rows[r].occ}});
      #3;
      e = sb.pop_front(); tests_run++;
      if ({22'b0, oStall, oFlush} !== e.val) begin tests_failed++; $display("FAIL %s[%0d] got %0h want %0h", e.name, r, {oStall, oFlush}, e.val); end
      tick();
      e = sb.pop_front(); tests_run++;
      if ({27'b0, oOccupied} !== e.val) begin tests_failed++; $display("FAIL %s[%0d] got %0h want %0h", e.name, r, oOccupied, e.val); end
    end
    idle_inputs();
  endtask

  task automatic test_halt_step();
    logic [N-1:0] drain_occ [6];
    logic [N-1:0] step_occ [6];
    drain_occ = '{5'b11110, 5'b11100, 5'b11000, 5'b10000, 5'b00000, 5'b00000};
    step_occ  = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00000};
    refill();
    iDbgHaltReq = 1'b1;
    sb.push_back(exp_t'{"halt_fetch_off", 32'h0});
    #3;
    e = sb.pop_front(); tests_run++;
    if ({31'b0, oFetchEn} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, oFetchEn, e.val); end
    tick();
    iDbgHaltReq = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sb.push_back(exp_t'{"halt_occ_halted", {26'b0, drain_occ[k], (k == 5) ? 1'b1 : 1'b0}});
      e = sb.pop_front(); tests_run++;
      if ({26'b0, oOccupied, oDbgHalted} !== e.val) begin tests_failed++; $display("FAIL %s[%0d] got %0h want %0h", e.name, k, {oOccupied, oDbgHalted}, e.val); end
      if (k < 5) tick();
    end
    iDbgStepReq = 1'b1;
    sb.push_back(exp_t'{"halted_stall_fetch", {26'b0, 5'b11111, 1'b0}});
    #3;
    e = sb.pop_front(); tests_run++;
    if ({26'b0, oStall, oFetchEn} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, {oStall, oFetchEn}, e.val); end
    tick();
    iDbgStepReq = 1'b0;
    sb.push_back(exp_t'{"step_fetch_halted", {30'b0, 1'b1, 1'b0}});
    #3;
    e = sb.pop_front(); tests_run++;
    if ({30'b0, oFetchEn, oDbgHalted} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, {oFetchEn, oDbgHalted}, e.val); end
    tick();
    for (int k = 0; k < 6; k++) begin
      sb.push_back(exp_t'{"step_walk", {26'b0, step_occ[k], 1'b0}});
      e = sb.pop_front(); tests_run++;
      if ({26'b0, oOccupied, oDbgHalted} !== e.val) begin tests_failed++; $display("FAIL %s[%0d] got %0h want %0h", e.name, k, {oOccupied, oDbgHalted}, e.val); end
      tick();
    end
    sb.push_back(exp_t'{"step_rehalted", 32'h1});
    e = sb.pop_front(); tests_run++;
    if ({31'b0, oDbgHalted} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, oDbgHalted, e.val); end
  endtask

  task automatic test_resume_step();
    iDbgResumeReq = 1'b1;
    iDbgStepReq = 1'b1;
    tick();
    idle_inputs();
    sb.push_back(exp_t'{"resume_fetch_halt_stall", {25'b0, 1'b1, 1'b0, 5'b00000}});
    #3;
    e = sb.pop_front(); tests_run++;
    if ({25'b0, oFetchEn, oDbgHalted, oStall} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, {oFetchEn, oDbgHalted, oStall}, e.val); end
    tick();
    sb.push_back(exp_t'{"resume_occ1", {27'b0, 5'b00001}});
    sb.push_back(exp_t'{"resume_fetch2", 32'h1});
    e = sb.pop_front(); tests_run++;
    if ({27'b0, oOccupied} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, oOccupied, e.val); end
    #3;
    e = sb.pop_front(); tests_run++;
    if ({31'b0, oFetchEn} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, oFetchEn, e.val); end
    tick();
    sb.push_back(exp_t'{"resume_occ2", {27'b0, 5'b00011}});
    e = sb.pop_front(); tests_run++;
    if ({27'b0, oOccupied} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, oOccupied, e.val); end
  endtask

  task automatic test_drain_timeout();
    refill();
    iStallReq = 5'b01000;
    iDbgHaltReq = 1'b1;
    tick();
    iDbgHaltReq = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      sb.push_back(exp_t'{"wdog_flush", (c == 16) ? 32'h1F : 32'h0});
      #3;
      e = sb.pop_front(); tests_run++;
      if ({27'b0, oFlush} !== e.val) begin tests_failed++; $display("FAIL %s[%0d] got %0h want %0h", e.name, c, oFlush, e.val); end
      tick();
    end
    sb.push_back(exp_t'{"wdog_to_halt_occ", {25'b0, 1'b1, 1'b1, 5'b00000}});
    e = sb.pop_front(); tests_run++;
    if ({25'b0, oDrainTimeout, oDbgHalted, oOccupied} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, {oDrainTimeout, oDbgHalted, oOccupied}, e.val); end
    iStallReq = '0;
    iDbgResumeReq = 1'b1;
    tick();
    iDbgResumeReq = 1'b0;
    sb.push_back(exp_t'{"resume_clears_to", 32'h0});
    e = sb.pop_front(); tests_run++;
    if ({30'b0, oDrainTimeout, oDbgHalted} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, {oDrainTimeout, oDbgHalted}, e.val); end
  endtask

  task automatic test_perf();
`ifdef PIPE_PERF_EN
    sb.push_back(exp_t'{"perf_stall", 32'd7});
    sb.push_back(exp_t'{"perf_flush", 32'd3});
`else
    sb.push_back(exp_t'{"perf_stall", 32'd0});
    sb.push_back(exp_t'{"perf_flush", 32'd0});
`endif
    e = sb.pop_front(); tests_run++;
    if (oPerfStall !== e.val) begin tests_failed++; $display("FAIL %s got %0d want %0d", e.name, oPerfStall, e.val); end
    e = sb.pop_front(); tests_run++;
    if (oPerfFlush !== e.val) begin tests_failed++; $display("FAIL %s got %0d want %0d", e.name, oPerfFlush, e.val); end
  endtask

  task automatic test_reset_mid_drain();
    refill();
    iDbgHaltReq = 1'b1;
    tick();
    iDbgHaltReq = 1'b0;
    tick();
    nRst = 1'b0;
    #1;
    sb.push_back(exp_t'{"mid_rst_flush_stall", {22'b0, 5'b11111, 5'b00000}});
    sb.push_back(exp_t'{"mid_rst_occ_halted", 32'h0});
    e = sb.pop_front(); tests_run++;
    if ({22'b0, oFlush, oStall} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, {oFlush, oStall}, e.val); end
    e = sb.pop_front(); tests_run++;
    if ({26'b0, oOccupied, oDbgHalted} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, {oOccupied, oDbgHalted}, e.val); end
    #2;
    nRst = 1'b1;
    tick();
    sb.push_back(exp_t'{"post_rst_run_occ", {27'b0, 5'b00001}});
    e = sb.pop_front(); tests_run++;
    if ({27'b0, oOccupied} !== e.val) begin tests_failed++; $display("FAIL %s got %0h want %0h", e.name, oOccupied, e.val); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_flush();
    test_load_use();
    test_halt_step();
    test_resume_step();
    test_drain_timeout();
    test_perf();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
